// File: rtl/player_anim_ctrl.sv
// ============================================================================
//  Module      : player_anim_ctrl
//  Description : Per-frame player state machine (idle / walk / attack) that
//                drives position, facing and animation period for the sprite.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module player_anim_ctrl #(
  parameter logic [7:0] X_INIT   = 8'd40,
  parameter logic [7:0] Y_INIT   = 8'd96,
  parameter logic [7:0] X_MIN    = 8'd4,
  parameter logic [7:0] X_MAX    = 8'd148,
  parameter logic [7:0] STEP     = 8'd1,
  parameter int         WALK_DIV = 6,
  parameter int         ATK_DIV  = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [1:0] behavior,
  output logic       isLeft,
  output logic [1:0] period
);

  localparam int CNT_MAX = (WALK_DIV > ATK_DIV) ? WALK_DIV : ATK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK_DIV - 1);
  localparam logic [CW-1:0] ATK_LAST  = CW'(ATK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_ATTACK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q;
  logic          left_q, left_d;
  logic [1:0]    period_q, period_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hist_q, hist_d;

  logic       w_trig;
  logic       w_one_dir;
  logic [7:0] w_x_left;
  logic [7:0] w_x_right;

  assign w_trig    = key_attack & ~hist_q;
  assign w_one_dir = key_left ^ key_right;
  // Saturating moves; comparisons done before the add/sub so x never wraps.
  assign w_x_left  = (x_q <= X_MIN + STEP) ? X_MIN : (x_q - STEP);
  assign w_x_right = (x_q >= X_MAX - STEP) ? X_MAX : (x_q + STEP);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      x_q      <= X_INIT;
      y_q      <= Y_INIT;
      left_q   <= 1'b0;
      period_q <= 2'd0;
      cnt_q    <= '0;
      hist_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      left_q   <= left_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    left_d   = left_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    hist_d   = hist_q;

    if (frame_tick) begin
      hist_d = key_attack;
      case (state_q)
        ST_IDLE, ST_WALK: begin
          if (w_trig) begin
            state_d  = ST_ATTACK;
            period_d = 2'd0;
            cnt_d    = '0;
          end else if (w_one_dir) begin
            state_d = ST_WALK;
            left_d  = key_left;
            x_d     = key_left ? w_x_left : w_x_right;
            if (state_q == ST_IDLE) begin
              period_d = 2'd0;
              cnt_d    = '0;
            end else if (cnt_q == WALK_LAST) begin
              cnt_d    = '0;
              period_d = period_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d  = ST_IDLE;
            period_d = 2'd0;
            cnt_d    = '0;
          end
        end
        ST_ATTACK: begin
          if (cnt_q == ATK_LAST) begin
            cnt_d = '0;
            if (period_q == 2'd3) begin
              state_d  = ST_IDLE;
              period_d = 2'd0;
            end else begin
              period_d = period_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          period_d = 2'd0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign isLeft   = left_q;
  assign period   = period_q;
  assign behavior = (state_q == ST_ATTACK) ? 2'd2 :
                    (state_q == ST_WALK)   ? 2'd1 : 2'd0;

endmodule

`default_nettype wire
